// File: rtl/digit_serial_subtractor_if.sv
// Start/busy/done handshake bundle for the digit-serial subtractor.
interface digit_serial_subtractor_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  // Requester side: issues operands and start, observes status and result.
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  // Subtractor side.
  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, bout = borrow-out.
// Processes DIGIT bits per clock, least significant digit first; the borrow
// crosses digit boundaries only through r_borrow.
module digit_serial_subtractor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input logic                      clk,
  input logic                      rst,
  digit_serial_subtractor_if.slave bus
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_borrow;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_busy;
  logic               r_done;

  int unsigned        w_base;
  logic [DIGIT-1:0]   w_a_dig;
  logic [DIGIT-1:0]   w_b_dig;
  logic [DIGIT:0]     w_sum;
  logic               w_last;

  // Current digit: A_j + ~B_j + ~borrow; sum MSB is the inverted borrow-out.
  always_comb begin
    w_base  = 32'(r_cnt) * DIGIT;
    w_a_dig = r_a[w_base +: DIGIT];
    w_b_dig = r_b[w_base +: DIGIT];
    w_sum   = {1'b0, w_a_dig} + {1'b0, ~w_b_dig} + {{DIGIT{1'b0}}, ~r_borrow};
    w_last  = (r_cnt == CNT_W'(N - 1));
  end

  // Control FSM and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.bin;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_diff[w_base +: DIGIT] <= w_sum[DIGIT-1:0];
          r_borrow                <= ~w_sum[DIGIT];
          r_cnt                   <= r_cnt + 1'b1;
          if (w_last) begin
            r_bout  <= ~w_sum[DIGIT];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed and random checks of digit_serial_subtractor with DIGIT = 8, 1, 32.
module tb_digit_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_start = 1'b0;
  logic [31:0] r_a = '0;
  logic [31:0] r_b = '0;
  logic        r_bin = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  digit_serial_subtractor_if #(.WIDTH(32)) if8 ();
  digit_serial_subtractor_if #(.WIDTH(32)) if1 ();
  digit_serial_subtractor_if #(.WIDTH(32)) if32 ();

  assign if8.start  = r_start;
  assign if8.a      = r_a;
  assign if8.b      = r_b;
  assign if8.bin    = r_bin;
  assign if1.start  = r_start;
  assign if1.a      = r_a;
  assign if1.b      = r_b;
  assign if1.bin    = r_bin;
  assign if32.start = r_start;
  assign if32.a     = r_a;
  assign if32.b     = r_b;
  assign if32.bin   = r_bin;

  digit_serial_subtractor #(.WIDTH(32), .DIGIT(8)) u_dut8 (
    .clk (clk), .rst (rst), .bus (if8.slave)
  );
  digit_serial_subtractor #(.WIDTH(32), .DIGIT(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );
  digit_serial_subtractor #(.WIDTH(32), .DIGIT(32)) u_dut32 (
    .clk (clk), .rst (rst), .bus (if32.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int unsigned c;
    c = 0;
    while ((if8.busy || if1.busy || if32.busy) && c < 64) begin
      tick();
      c++;
    end
    if (if8.busy || if1.busy || if32.busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Runs one operation on all three instances and checks result, latency,
  // busy width and single done pulse against a 33-bit reference.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic bin);
    logic [32:0] full;
    logic [31:0] exp_diff;
    logic        exp_bout;
    logic [31:0] d8, d1, d32;
    logic        b8, b1, b32;
    int unsigned lat8, lat1, lat32, busy8, done8;
    full     = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    exp_diff = full[31:0];
    exp_bout = ({1'b0, a} < ({1'b0, b} + {32'd0, bin}));
    lat8 = 0; lat1 = 0; lat32 = 0; busy8 = 0; done8 = 0;
    d8 = '0; d1 = '0; d32 = '0; b8 = 1'b0; b1 = 1'b0; b32 = 1'b0;
    wait_idle();
    r_a = a; r_b = b; r_bin = bin; r_start = 1'b1;
    tick();
    r_start = 1'b0;
    if (if8.busy) busy8++;
    for (int unsigned c = 1; c <= 40; c++) begin
      tick();
      if (if8.busy) busy8++;
      if (if8.done) done8++;
      if (if8.done && lat8 == 0) begin lat8 = c; d8 = if8.diff; b8 = if8.bout; end
      if (if1.done && lat1 == 0) begin lat1 = c; d1 = if1.diff; b1 = if1.bout; end
      if (if32.done && lat32 == 0) begin lat32 = c; d32 = if32.diff; b32 = if32.bout; end
      if (lat8 != 0 && lat1 != 0 && lat32 != 0 && c > lat8) break;
    end
    check($sformatf("%s_diff8", tag), 64'(d8), 64'(exp_diff));
    check($sformatf("%s_bout8", tag), 64'(b8), 64'(exp_bout));
    check($sformatf("%s_lat8", tag), 64'(lat8), 64'd4);
    check($sformatf("%s_busy8", tag), 64'(busy8), 64'd4);
    check($sformatf("%s_done8", tag), 64'(done8), 64'd1);
    check($sformatf("%s_diff1", tag), 64'(d1), 64'(exp_diff));
    check($sformatf("%s_bout1", tag), 64'(b1), 64'(exp_bout));
    check($sformatf("%s_lat1", tag), 64'(lat1), 64'd32);
    check($sformatf("%s_diff32", tag), 64'(d32), 64'(exp_diff));
    check($sformatf("%s_bout32", tag), 64'(b32), 64'(exp_bout));
    check($sformatf("%s_lat32", tag), 64'(lat32), 64'd1);
  endtask

  initial begin
    int unsigned ndone;
    logic [31:0] ra, rb;

    // Reset state
    repeat (3) tick();
    check("rst_busy", 64'(if8.busy), 64'd0);
    check("rst_done", 64'(if8.done), 64'd0);
    check("rst_diff", 64'(if8.diff), 64'd0);
    check("rst_bout", 64'(if8.bout), 64'd0);
    rst = 1'b0;
    tick();

    // Directed vectors
    run_op("sub5_3",   32'd5,          32'd3,          1'b0);
    run_op("sub0_1",   32'd0,          32'd1,          1'b0);
    run_op("xdigit",   32'h0000_0100,  32'h0000_0001,  1'b0);
    run_op("eq_bin1",  32'h1234_5678,  32'h1234_5678,  1'b1);
    run_op("eq_bin0",  32'h1234_5678,  32'h1234_5678,  1'b0);
    run_op("max_0",    32'hFFFF_FFFF,  32'h0,          1'b1);
    run_op("0_max",    32'h0,          32'hFFFF_FFFF,  1'b1);

    // Start during busy is ignored; back-to-back start in the done cycle
    wait_idle();
    r_a = 32'd10; r_b = 32'd4; r_bin = 1'b0; r_start = 1'b1;
    tick();
    r_start = 1'b0;
    check("ign_busy0", 64'(if8.busy), 64'd1);
    tick();
    r_a = 32'd1; r_b = 32'd2; r_start = 1'b1;
    tick();
    r_start = 1'b0;
    check("ign_done2", 64'(if8.done), 64'd0);
    check("ign_busy2", 64'(if8.busy), 64'd1);
    tick();
    check("ign_done3", 64'(if8.done), 64'd0);
    tick();
    check("ign_done4", 64'(if8.done), 64'd1);
    check("ign_diff", 64'(if8.diff), 64'd6);
    check("ign_bout", 64'(if8.bout), 64'd0);
    r_a = 32'd1; r_b = 32'd2; r_bin = 1'b0; r_start = 1'b1;
    tick();
    r_start = 1'b0;
    check("b2b_done_drop", 64'(if8.done), 64'd0);
    check("b2b_busy", 64'(if8.busy), 64'd1);
    check("b2b_diff_hold", 64'(if8.diff), 64'd6);
    tick();
    check("b2b_diff_d0", 64'(if8.diff), 64'h0000_00FF);
    tick();
    tick();
    check("b2b_done3", 64'(if8.done), 64'd0);
    tick();
    check("b2b_done4", 64'(if8.done), 64'd1);
    check("b2b_diff", 64'(if8.diff), 64'hFFFF_FFFF);
    check("b2b_bout", 64'(if8.bout), 64'd1);
    tick();
    check("b2b_pulse", 64'(if8.done), 64'd0);
    check("b2b_hold", 64'(if8.diff), 64'hFFFF_FFFF);

    // Reset in the middle of an operation
    wait_idle();
    r_a = 32'h0000_0055; r_b = 32'h0000_0011; r_bin = 1'b0; r_start = 1'b1;
    tick();
    r_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 64'(if8.busy), 64'd0);
    check("mid_rst_done", 64'(if8.done), 64'd0);
    check("mid_rst_diff", 64'(if8.diff), 64'd0);
    check("mid_rst_bout", 64'(if8.bout), 64'd0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if8.done) ndone++;
    end
    check("mid_rst_nodone", 64'(ndone), 64'd0);
    run_op("post_rst", 32'h0000_0055, 32'h0000_0011, 1'b0);

    // Random operands against the reference
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = (i % 8 == 0) ? ra : $urandom;
      run_op("rnd", ra, rb, 1'($urandom_range(1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
